// File: rtl/lane_det_pkg.sv
// rtl/lane_det_pkg.sv - density codes, default sizing constants and the shared count quantiser
package lane_det_pkg;

    localparam logic [1:0] DENS_NONE  = 2'd0;
    localparam logic [1:0] DENS_LIGHT = 2'd1;
    localparam logic [1:0] DENS_MED   = 2'd2;
    localparam logic [1:0] DENS_HEAVY = 2'd3;

    localparam int DEF_DEBOUNCE_CYC  = 4;
    localparam int DEF_WINDOW_CYC    = 1000;
    localparam int DEF_CNT_W         = 8;
    localparam int DEF_TH1           = 2;
    localparam int DEF_TH2           = 5;
    localparam int DEF_TH3           = 9;
    localparam int DEF_PRESENCE_HOLD = 50;

    // Callers pass the count and thresholds already reduced to the counter width.
    function automatic logic [1:0] quantise(input logic [31:0] cnt,
                                            input logic [31:0] th1,
                                            input logic [31:0] th2,
                                            input logic [31:0] th3);
        if (cnt < th1)      return DENS_NONE;
        else if (cnt < th2) return DENS_LIGHT;
        else if (cnt < th3) return DENS_MED;
        else                return DENS_HEAVY;
    endfunction

endpackage

// File: rtl/lane_sensor_filter.sv
// rtl/lane_sensor_filter.sv - per-road synchroniser, debounce, vehicle edge and presence hold
module lane_sensor_filter
    import lane_det_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int PRESENCE_HOLD = DEF_PRESENCE_HOLD
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic sensor,
    output logic vehicle_event,
    output logic presence
);

    localparam int DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int HOLD_W = (PRESENCE_HOLD > 1) ? $clog2(PRESENCE_HOLD + 1) : 1;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(PRESENCE_HOLD);

    logic              sync_meta;
    logic              sync;
    logic              filt;
    logic [DEB_W-1:0]  deb;
    logic [HOLD_W-1:0] hold;
    logic              flip;
    logic              rise;
    logic              fall;

    // Strobes fire in the cycle before filt changes so the hold timer loads
    // on the same edge filt drops and presence never blinks low.
    assign flip = (sync != filt) && (deb == DEB_LAST);
    assign rise = flip & sync;
    assign fall = flip & ~sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta     <= 1'b0;
            sync          <= 1'b0;
            filt          <= 1'b0;
            deb           <= '0;
            hold          <= '0;
            vehicle_event <= 1'b0;
        end else begin
            sync_meta     <= sensor;
            sync          <= sync_meta;
            vehicle_event <= rise;

            if (sync == filt) begin
                deb <= '0;
            end else if (deb == DEB_LAST) begin
                filt <= sync;
                deb  <= '0;
            end else begin
                deb <= deb + 1'b1;
            end

            if (clr || rise)       hold <= '0;
            else if (fall)         hold <= HOLD_INIT;
            else if (hold != '0)   hold <= hold - 1'b1;
        end
    end

    assign presence = filt | (hold != '0);

endmodule

// File: rtl/lane_density_estimator.sv
// rtl/lane_density_estimator.sv - per-road vehicle counting and density quantisation; DENSITY_SMOOTH_EN averages with previous window
module lane_density_estimator
    import lane_det_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int WINDOW_CYC    = DEF_WINDOW_CYC,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int TH1           = DEF_TH1,
    parameter int TH2           = DEF_TH2,
    parameter int TH3           = DEF_TH3,
    parameter int PRESENCE_HOLD = DEF_PRESENCE_HOLD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       sensor_a,
    input  logic       sensor_b,
    input  logic       sensor_c,
    input  logic       sensor_d,
    output logic [1:0] TA,
    output logic [1:0] TB,
    output logic [1:0] TC,
    output logic [1:0] TD,
    output logic       VA,
    output logic       VB,
    output logic       VC,
    output logic       VD,
    output logic       window_tick
);

    localparam int WIN_W = $clog2(WINDOW_CYC);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] TH1_W    = CNT_W'(TH1);
    localparam logic [CNT_W-1:0] TH2_W    = CNT_W'(TH2);
    localparam logic [CNT_W-1:0] TH3_W    = CNT_W'(TH3);

    logic [3:0]       sensors;
    logic [3:0]       veh_event;
    logic [3:0]       presence;
    logic [WIN_W-1:0] win_cnt;
    logic             terminal;
    logic             tick;
    logic [CNT_W-1:0] veh_cnt   [4];
    logic [1:0]       dens      [4];
    logic [1:0]       dens_next [4];
    logic [CNT_W-1:0] q_in      [4];
`ifdef DENSITY_SMOOTH_EN
    logic [CNT_W-1:0] prev_cnt  [4];
    logic [CNT_W:0]   smooth_sum[4];
`endif

    assign sensors  = {sensor_d, sensor_c, sensor_b, sensor_a};
    assign terminal = (win_cnt == WIN_LAST);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        lane_sensor_filter #(
            .DEBOUNCE_CYC  (DEBOUNCE_CYC),
            .PRESENCE_HOLD (PRESENCE_HOLD)
        ) u_filter (
            .clk           (clk),
            .rst           (rst),
            .clr           (clr),
            .sensor        (sensors[g]),
            .vehicle_event (veh_event[g]),
            .presence      (presence[g])
        );

`ifdef DENSITY_SMOOTH_EN
        // One extra bit keeps the two-window sum exact before halving.
        assign smooth_sum[g] = {1'b0, prev_cnt[g]} + {1'b0, veh_cnt[g]};
        assign q_in[g]       = smooth_sum[g][CNT_W:1];
`else
        assign q_in[g]       = veh_cnt[g];
`endif
        assign dens_next[g] = quantise(32'(q_in[g]), 32'(TH1_W), 32'(TH2_W), 32'(TH3_W));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt <= '0;
            tick    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                veh_cnt[i]  <= '0;
                dens[i]     <= DENS_NONE;
`ifdef DENSITY_SMOOTH_EN
                prev_cnt[i] <= '0;
`endif
            end
        end else if (clr) begin
            win_cnt <= '0;
            tick    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                veh_cnt[i]  <= '0;
                dens[i]     <= DENS_NONE;
`ifdef DENSITY_SMOOTH_EN
                prev_cnt[i] <= '0;
`endif
            end
        end else begin
            tick    <= terminal;
            win_cnt <= terminal ? '0 : win_cnt + 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (terminal) begin
                    // A terminal-cycle event opens the next window's count.
                    dens[i]     <= dens_next[i];
                    veh_cnt[i]  <= CNT_W'(veh_event[i]);
`ifdef DENSITY_SMOOTH_EN
                    prev_cnt[i] <= veh_cnt[i];
`endif
                end else if (veh_event[i] && (veh_cnt[i] != CNT_MAX)) begin
                    veh_cnt[i] <= veh_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign TA          = dens[0];
    assign TB          = dens[1];
    assign TC          = dens[2];
    assign TD          = dens[3];
    assign VA          = presence[0];
    assign VB          = presence[1];
    assign VC          = presence[2];
    assign VD          = presence[3];
    assign window_tick = tick;

endmodule
